// File: rtl/mem_ctrl_pkg.sv
// Shared types and lane helpers for the memory request controller.
// Holds the access-size and state enums plus the extract/merge functions.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_CAPT = 3'd2,
    WR_REQ  = 3'd3,
    WR_GAP  = 3'd4
  } ctrl_state_e;

  // Size code 3 is not a member of mem_size_e, so this check takes the raw 2-bit field.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      2'd1:    bad = off[0];
      2'd2:    bad = (off != 2'b00);
      2'd3:    bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input mem_size_e   size,
                                               input logic        is_unsigned);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = rdata >> {off, 3'b000};
    case (size)
      BYTE:    result = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      HALF:    result = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: result = rdata;
    endcase
    return result;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] rdata,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  off,
                                             input mem_size_e   size);
    logic [31:0] mask;
    logic [31:0] placed;
    case (size)
      BYTE:    mask = 32'h0000_00FF << {off, 3'b000};
      HALF:    mask = 32'h0000_FFFF << {off, 3'b000};
      default: mask = 32'hFFFF_FFFF;
    endcase
    placed = wdata << {off, 3'b000};
    return (rdata & ~mask) | (placed & mask);
  endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Core-side request/response bundle of the memory request controller.
// The core drives through 'master'; the controller attaches through 'slave'.
interface mem_req_ctrl_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_req_ctrl_lane_align.sv
// Combinational lane logic: extends a loaded lane and merges a sub-word
// store into the word just read back from memory.
module lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  assign load_data  = lane_extract(rdata, off, size, is_unsigned);
  assign store_data = lane_merge(rdata, wdata, off, size);

endmodule

// File: rtl/mem_req_ctrl.sv
// Request controller in front of the single-port memory: strobe generation,
// load extension, read-modify-write for sub-word stores and optional timeout.
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_req_ctrl_if.slave         core,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_resp
);

  localparam int CNT_W = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  ctrl_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic                  uns_q, uns_d;
  mem_size_e             size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           mwdata_q, mwdata_d;
  logic                  to_err_q, to_err_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic [31:0]           load_data;
  logic [31:0]           store_data;
  logic                  timed_out;

  lane_align u_lane_align (
    .rdata       (mem_rdata),
    .wdata       (wdata_q),
    .off         (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  // Counter already holds the cycles spent in the strobe state minus one.
  assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST) && !mem_resp;

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    we_d        = we_q;
    uns_d       = uns_q;
    size_d      = size_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    mwdata_d    = mwdata_q;
    to_err_d    = to_err_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (core.req_valid) begin
          if (req_illegal(core.req_size, core.req_addr[1:0])) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            we_d     = core.req_we;
            uns_d    = core.req_unsigned;
            size_d   = mem_size_e'(core.req_size);
            off_d    = core.req_addr[1:0];
            wdata_d  = core.req_wdata;
            addr_d   = {core.req_addr[ADDR_WIDTH-1:2], 2'b00};
            to_err_d = 1'b0;
            if (core.req_we && (core.req_size == 2'd2)) begin
              mwdata_d = core.req_wdata;
              state_d  = WR_REQ;
            end else begin
              state_d  = RD_REQ;
            end
          end
        end
      end
      RD_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_resp) begin
          state_d = RD_CAPT;
        end else if (timed_out) begin
          to_err_d = 1'b1;
          state_d  = WR_GAP;
        end
      end
      RD_CAPT: begin
        if (we_q) begin
          mwdata_d = store_data;
          state_d  = WR_REQ;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_data;
          state_d     = IDLE;
        end
      end
      WR_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_resp) begin
          state_d = WR_GAP;
        end else if (timed_out) begin
          to_err_d = 1'b1;
          state_d  = WR_GAP;
        end
      end
      WR_GAP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = to_err_q;
        rsp_rdata_d = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= BYTE;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      addr_q      <= '0;
      mwdata_q    <= '0;
      to_err_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      size_q      <= size_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      mwdata_q    <= mwdata_d;
      to_err_q    <= to_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Strobes decode straight from the state register, so reset drops them at once.
  assign mem_read       = (state_q == RD_REQ);
  assign mem_write      = (state_q == WR_REQ);
  assign mem_addr       = addr_q;
  assign mem_wdata      = mwdata_q;
  assign core.req_ready = (state_q == IDLE) & rst_n;
  assign core.rsp_valid = rsp_valid_q;
  assign core.rsp_err   = rsp_err_q;
  assign core.rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Upstream request controller feeding the single-port `memory_model`. Accepts byte/half/word load and store requests from the core over a valid/ready handshake and word-aligns the address. Generates the memory's edge-sensitive `read`/`write` strobes, holding address and data stable until `resp`. Captures the registered read data, performs lane extraction with sign/zero extension, and turns sub-word stores into read-modify-write sequences. An optional timeout aborts a hung access.

## Interface
- `ADDR_WIDTH`, default 32: byte address width on both the core and memory sides.
- `TIMEOUT`, default 0: maximum cycles to wait for `mem_resp` in a strobe state; 0 disables the timeout.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  core request valid.
- `req_ready`  out  1  controller can accept; equals (state==IDLE) & rst_n.
- `req_we`  in  1  1=store, 0=load.
- `req_size`  in  2  0=byte, 1=half, 2=word, 3=illegal.
- `req_unsigned`  in  1  zero-extend loads (1) vs sign-extend (0).
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned/illegal request or timeout; qualified by `rsp_valid`.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `mem_addr`  out  ADDR_WIDTH  word-aligned address {req_addr[ADDR_WIDTH-1:2],2'b00}.
- `mem_wdata`  out  32  word to write.
- `mem_rdata`  in  32  memory output buffer.
- `mem_resp`  in  1  memory done pulse.

## Operation
- States: IDLE, RD_REQ, RD_CAPT, WR_REQ, WR_GAP.
- On accept (req_valid & req_ready), latch the request and check alignment:
  - Illegal: size 3, half with addr[0]=1, or word with addr[1:0]≠0.
  - Illegal requests cause no memory access and stay in IDLE; rsp_valid=1, rsp_err=1 next cycle.
- Load (any size) and sub-word store go to RD_REQ. Word store goes to WR_REQ with mem_wdata=req_wdata.
- RD_REQ: mem_read=1 until mem_resp, then → RD_CAPT.
- RD_CAPT: mem_read=0; latch mem_rdata (valid the cycle after resp).
  - Load: extract the lane, extend it, → IDLE with rsp_valid pulse.
  - Sub-word store: merge into mem_wdata, → WR_REQ.
  - Extraction: byte = rdata[8*off+:8]; half = rdata[8*off+:16], off=addr[1:0].
  - Merge: byte replaces lane off with wdata[7:0]; half replaces bytes off, off+1 with wdata[15:0].
- WR_REQ: mem_write=1 until mem_resp, then → WR_GAP.
- WR_GAP: mem_write=0, → IDLE with rsp_valid pulse, rsp_err=0.
- Timeout (TIMEOUT≠0): cycle counter clears on entering RD_REQ/WR_REQ and increments each cycle there.
  - When it reaches TIMEOUT with no mem_resp: drop the strobe, → WR_GAP, then respond with rsp_err=1, rsp_rdata=0.
  - Counter width is $clog2(TIMEOUT+1), min 1.
- mem_resp is ignored outside RD_REQ/WR_REQ.

## Timing
- Reset (asynchronous, immediate): state=IDLE; mem_read=mem_write=0; rsp_valid=rsp_err=0; rsp_rdata=0; mem_addr=mem_wdata=0.
- req_ready=0 while rst_n is low. Reset mid-access abandons it with no response.
- Accept at cycle N → strobe high from N+1.
- mem_resp seen at cycle M → strobe low at M+1.
- Response cycle:
  - Load or word store: rsp_valid at M+2.
  - Sub-word store: read resp at M, write strobe from M+2, write resp at W, rsp_valid at W+2.
- Strobes are low for ≥1 cycle between accesses, guaranteeing a fresh rising edge to the memory.
- mem_addr and mem_wdata are stable from strobe assertion through the cycle after mem_resp.
- Back-to-back requests are allowed: the rsp_valid cycle is IDLE with req_ready=1.
- rsp_rdata/rsp_err hold until the next response.

## Structure
- `mem_ctrl_pkg` holds:
  - the `mem_size_e` enum (BYTE, HALF, WORD);
  - the controller state enum;
  - the lane extract and merge functions.
- One sub-module, `lane_align`: combinational extract/extend and merge, instantiated once.
- Counter and FSM stay in the top module.

## Test plan
- Reset mid-RD_REQ (rst_n low 1 cycle): mem_read drops immediately, no rsp_valid afterwards, next request completes normally.
- Word load at 0x10, memory word 0x8899AABB → rsp_rdata=0x8899AABB, rsp_err=0, rsp_valid exactly 2 cycles after mem_resp.
- Byte load at 0x13, word 0x8899AABB: signed → 0xFFFFFF88; unsigned → 0x00000088. Half load at 0x12 signed → 0xFFFF8899.
- Byte store 0x5A at 0x11 over 0x11223344 → read then write, memory holds 0x11225A44, exactly one mem_read and one mem_write pulse.
- Word store at 0x06 and half load at 0x03 → rsp_err=1 the cycle after accept, mem_read/mem_write never asserted.
- TIMEOUT=8 with mem_resp tied 0 → strobe high exactly 8 cycles, rsp_valid with rsp_err=1 and rsp_rdata=0, then req_ready=1.
